// File: rtl/floo_axi_txn_throttle.sv
// Zero-latency AXI4+ATOP limiter in front of a memory controller: caps in-flight
// reads/writes and holds W beats back until the AW they belong to has been forwarded.

package floo_axi_txn_throttle_pkg;

  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned UserWidth = 1;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
    logic [3:0]           region;
    logic [5:0]           atop;
    logic [UserWidth-1:0] user;
  } aw_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] strb;
    logic                   last;
    logic [UserWidth-1:0]   user;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [1:0]           resp;
    logic [UserWidth-1:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic                 lock;
    logic [3:0]           cache;
    logic [2:0]           prot;
    logic [3:0]           qos;
    logic [3:0]           region;
    logic [UserWidth-1:0] user;
  } ar_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
    logic [UserWidth-1:0] user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_rsp_t;

endpackage

module floo_axi_txn_throttle #(
  parameter int unsigned MaxReadTxns  = 16,
  parameter int unsigned MaxWriteTxns = 16,
  parameter type axi_req_t = floo_axi_txn_throttle_pkg::axi_req_t,
  parameter type axi_rsp_t = floo_axi_txn_throttle_pkg::axi_rsp_t,
  localparam int unsigned RdCntWidth = $clog2(MaxReadTxns + 1),
  localparam int unsigned WrCntWidth = $clog2(MaxWriteTxns + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  axi_req_t              slv_req_i,
  output axi_rsp_t              slv_rsp_o,
  output axi_req_t              mst_req_o,
  input  axi_rsp_t              mst_rsp_i,
  output logic [RdCntWidth-1:0] rd_inflight_o,
  output logic [WrCntWidth-1:0] wr_inflight_o
);

  localparam logic [RdCntWidth-1:0] RdMax  = RdCntWidth'(MaxReadTxns);
  localparam logic [RdCntWidth-1:0] RdLast = RdCntWidth'(MaxReadTxns - 1);
  localparam logic [WrCntWidth-1:0] WrMax  = WrCntWidth'(MaxWriteTxns);

  logic [RdCntWidth-1:0] rd_cnt_reg, rd_cnt_next;
  logic [WrCntWidth-1:0] wr_cnt_reg, wr_cnt_next;
  logic [WrCntWidth-1:0] w_pend_reg, w_pend_next;

  logic needs_r, rd_room, ar_ok, aw_ok, w_ok;
  logic ar_hs, aw_hs, w_last_hs, r_last_hs, b_hs;

  // All gating is derived from registered counts only, so a slot released by
  // an R/B handshake becomes usable one cycle later and no comb loop exists.
  assign needs_r = slv_req_i.aw.atop[5];
  assign rd_room = rd_cnt_reg < RdMax;
  assign ar_ok   = rd_room;
  // The last read slot is reserved for a waiting AR over an R-returning ATOP.
  assign aw_ok   = (wr_cnt_reg < WrMax) &
                   (!needs_r | (rd_room & !(slv_req_i.ar_valid & (rd_cnt_reg == RdLast))));
  assign w_ok    = w_pend_reg != '0;

  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.ar_valid = slv_req_i.ar_valid & ar_ok;
    mst_req_o.aw_valid = slv_req_i.aw_valid & aw_ok;
    mst_req_o.w_valid  = slv_req_i.w_valid & w_ok;
  end

  always_comb begin
    slv_rsp_o          = mst_rsp_i;
    slv_rsp_o.ar_ready = mst_rsp_i.ar_ready & ar_ok;
    slv_rsp_o.aw_ready = mst_rsp_i.aw_ready & aw_ok;
    slv_rsp_o.w_ready  = mst_rsp_i.w_ready & w_ok;
  end

  assign ar_hs     = slv_req_i.ar_valid & ar_ok & mst_rsp_i.ar_ready;
  assign aw_hs     = slv_req_i.aw_valid & aw_ok & mst_rsp_i.aw_ready;
  assign w_last_hs = slv_req_i.w_valid & w_ok & mst_rsp_i.w_ready & slv_req_i.w.last;
  assign r_last_hs = mst_rsp_i.r_valid & slv_req_i.r_ready & mst_rsp_i.r.last;
  assign b_hs      = mst_rsp_i.b_valid & slv_req_i.b_ready;

  always_comb begin
    rd_cnt_next = rd_cnt_reg + RdCntWidth'(ar_hs) + RdCntWidth'(aw_hs & needs_r)
                  - RdCntWidth'(r_last_hs);
    wr_cnt_next = wr_cnt_reg + WrCntWidth'(aw_hs) - WrCntWidth'(b_hs);
    w_pend_next = w_pend_reg + WrCntWidth'(aw_hs) - WrCntWidth'(w_last_hs);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_cnt_reg <= '0;
      wr_cnt_reg <= '0;
      w_pend_reg <= '0;
    end else begin
      rd_cnt_reg <= rd_cnt_next;
      wr_cnt_reg <= wr_cnt_next;
      w_pend_reg <= w_pend_next;
    end
  end

  assign rd_inflight_o = rd_cnt_reg;
  assign wr_inflight_o = wr_cnt_reg;

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (!rst_ni) rd_cnt_reg <= RdMax);
  assert property (@(posedge clk_i) disable iff (!rst_ni) wr_cnt_reg <= WrMax);
  assert property (@(posedge clk_i) disable iff (!rst_ni) w_pend_reg <= wr_cnt_reg);
  assert property (@(posedge clk_i) disable iff (!rst_ni) r_last_hs |-> rd_cnt_reg != '0);
  assert property (@(posedge clk_i) disable iff (!rst_ni) b_hs |-> wr_cnt_reg != '0);

  // Upstream must hold a stalled request steady, even while we are the ones stalling it.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    slv_req_i.ar_valid & !slv_rsp_o.ar_ready |=> slv_req_i.ar_valid & $stable(slv_req_i.ar));
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    slv_req_i.aw_valid & !slv_rsp_o.aw_ready |=> slv_req_i.aw_valid & $stable(slv_req_i.aw));
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    slv_req_i.w_valid & !slv_rsp_o.w_ready |=> slv_req_i.w_valid & $stable(slv_req_i.w));
`endif

endmodule

// File: tb/tb_floo_axi_txn_throttle.sv
// Bench for floo_axi_txn_throttle (MaxReadTxns=4, MaxWriteTxns=4): scenario tasks plus a
// scoreboard that pops expected AR/AW/W payloads as they are handshaken at the master port.
module tb_floo_axi_txn_throttle;
  import floo_axi_txn_throttle_pkg::*;

  localparam int unsigned MaxRd = 4;
  localparam int unsigned MaxWr = 4;

  logic     clk_i = 1'b0;
  logic     rst_ni = 1'b0;
  axi_req_t slv_req, mst_req;
  axi_rsp_t slv_rsp, mst_rsp;
  logic [$clog2(MaxRd+1)-1:0] rd_inflight;
  logic [$clog2(MaxWr+1)-1:0] wr_inflight;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] exp_ar_q[$];
  logic [3:0]  exp_aw_q[$];
  logic [63:0] exp_w_q[$];

  always #5 clk_i = ~clk_i;

  floo_axi_txn_throttle #(
    .MaxReadTxns (MaxRd),
    .MaxWriteTxns(MaxWr),
    .axi_req_t   (axi_req_t),
    .axi_rsp_t   (axi_rsp_t)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .slv_req_i    (slv_req),
    .slv_rsp_o    (slv_rsp),
    .mst_req_o    (mst_req),
    .mst_rsp_i    (mst_rsp),
    .rd_inflight_o(rd_inflight),
    .wr_inflight_o(wr_inflight)
  );

  // Scoreboard: every master-side handshake must match the oldest expected entry.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (mst_req.ar_valid && mst_rsp.ar_ready) begin
        tests_run++;
        if (exp_ar_q.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_ar: got unexpected AR addr=%h, want none", mst_req.ar.addr);
        end else begin
          if (mst_req.ar.addr !== exp_ar_q[0] || slv_rsp.ar_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL sb_ar: got addr=%h rdy=%b, want addr=%h rdy=1",
                     mst_req.ar.addr, slv_rsp.ar_ready, exp_ar_q[0]);
          end
          $display("[SB] AR addr=%h", exp_ar_q.pop_front());
        end
      end
      if (mst_req.aw_valid && mst_rsp.aw_ready) begin
        tests_run++;
        if (exp_aw_q.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_aw: got unexpected AW id=%h, want none", mst_req.aw.id);
        end else begin
          if (mst_req.aw.id !== exp_aw_q[0] || slv_rsp.aw_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL sb_aw: got id=%h rdy=%b, want id=%h rdy=1",
                     mst_req.aw.id, slv_rsp.aw_ready, exp_aw_q[0]);
          end
          $display("[SB] AW id=%h atop=%h", exp_aw_q.pop_front(), mst_req.aw.atop);
        end
      end
      if (mst_req.w_valid && mst_rsp.w_ready) begin
        tests_run++;
        if (exp_w_q.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_w: got unexpected W data=%h, want none", mst_req.w.data);
        end else begin
          if (mst_req.w.data !== exp_w_q[0] || slv_rsp.w_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL sb_w: got data=%h rdy=%b, want data=%h rdy=1",
                     mst_req.w.data, slv_rsp.w_ready, exp_w_q[0]);
          end
          $display("[SB] W data=%h last=%b", exp_w_q.pop_front(), mst_req.w.last);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200us, want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue_ar(input logic [31:0] addr);
    bit got = 1'b0;
    exp_ar_q.push_back(addr);
    slv_req.ar.addr  = addr;
    slv_req.ar_valid = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk_i);
      got = slv_rsp.ar_ready;
      tick();
    end
    slv_req.ar_valid = 1'b0;
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL ar_timeout: got no accept for addr=%h, want accept in 20 cycles", addr);
    end
  endtask

  task automatic issue_aw(input logic [3:0] id, input logic [5:0] atop);
    bit got = 1'b0;
    exp_aw_q.push_back(id);
    slv_req.aw.id    = id;
    slv_req.aw.len   = 8'd0;
    slv_req.aw.atop  = atop;
    slv_req.aw_valid = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk_i);
      got = slv_rsp.aw_ready;
      tick();
    end
    slv_req.aw_valid = 1'b0;
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL aw_timeout: got no accept for id=%h, want accept in 20 cycles", id);
    end
  endtask

  task automatic send_w(input int beats, input logic [63:0] base);
    bit got;
    for (int b = 0; b < beats; b++) begin
      got = 1'b0;
      exp_w_q.push_back(base + 64'(b));
      slv_req.w.data  = base + 64'(b);
      slv_req.w.last  = (b == beats - 1);
      slv_req.w_valid = 1'b1;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge clk_i);
        got = slv_rsp.w_ready;
        tick();
      end
      tests_run++;
      if (!got) begin
        tests_failed++;
        $display("FAIL w_timeout: got no accept for beat %0d, want accept in 20 cycles", b);
      end
    end
    slv_req.w_valid = 1'b0;
    slv_req.w.last  = 1'b0;
  endtask

  task automatic b_pulse();
    mst_rsp.b_valid = 1'b1;
    tick();
    mst_rsp.b_valid = 1'b0;
  endtask

  task automatic drain_reads();
    for (int c = 0; c < 20 && rd_inflight != 0; c++) begin
      mst_rsp.r_valid = 1'b1;
      tick();
      mst_rsp.r_valid = 1'b0;
    end
    tests_run++;
    if (rd_inflight !== 3'd0) begin
      tests_failed++;
      $display("FAIL drain_reads: got rd_inflight=%0d, want 0", rd_inflight);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    slv_req.ar.addr  = 32'hDEAD_0000;
    slv_req.ar_valid = 1'b1;
    slv_req.aw_valid = 1'b1;
    slv_req.w_valid  = 1'b1;
    tick();
    tick();
    @(negedge clk_i);
    tests_run++;
    if (rd_inflight !== 3'd0 || wr_inflight !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_cnt: got rd=%0d wr=%0d, want rd=0 wr=0", rd_inflight, wr_inflight);
    end
    tests_run++;
    if (mst_req.ar_valid !== 1'b1 || mst_req.aw_valid !== 1'b1 || mst_req.w_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_gates: got ar=%b aw=%b w=%b, want ar=1 aw=1 w=0",
               mst_req.ar_valid, mst_req.aw_valid, mst_req.w_valid);
    end
    tests_run++;
    if (mst_req.ar.addr !== 32'hDEAD_0000) begin
      tests_failed++;
      $display("FAIL reset_payload: got ar.addr=%h, want dead0000", mst_req.ar.addr);
    end
    tick();
    slv_req.ar_valid = 1'b0;
    slv_req.aw_valid = 1'b0;
    slv_req.w_valid  = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    mst_rsp.ar_ready = 1'b1;
    mst_rsp.aw_ready = 1'b1;
    mst_rsp.w_ready  = 1'b1;
    tick();
  endtask

  task automatic test_read_limit();
    int idx = 0;
    bit hs;
    for (int i = 0; i < 6; i++) exp_ar_q.push_back(32'h1000 + 32'(i) * 32'h40);
    slv_req.ar.addr  = 32'h1000;
    slv_req.ar_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      hs = slv_rsp.ar_ready;
      tick();
      if (hs) begin
        idx++;
        slv_req.ar.addr = 32'h1000 + 32'(idx) * 32'h40;
      end
    end
    tests_run++;
    if (idx != 4 || rd_inflight !== 3'd4) begin
      tests_failed++;
      $display("FAIL rl_full: got fwd=%0d rd=%0d, want fwd=4 rd=4", idx, rd_inflight);
    end
    @(negedge clk_i);
    tests_run++;
    if (slv_rsp.ar_ready !== 1'b0 || mst_req.ar_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rl_stall: got ar_ready=%b mst_ar_valid=%b, want 0 0",
               slv_rsp.ar_ready, mst_req.ar_valid);
    end
    tick();
    mst_rsp.r_valid  = 1'b1;
    mst_rsp.r.data   = 64'hCAFE_F00D;
    @(negedge clk_i);
    tests_run++;
    if (slv_rsp.r_valid !== 1'b1 || slv_rsp.r.data !== 64'hCAFE_F00D || slv_rsp.ar_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL rl_release_cycle: got r_valid=%b r.data=%h ar_ready=%b, want 1 cafef00d 0",
               slv_rsp.r_valid, slv_rsp.r.data, slv_rsp.ar_ready);
    end
    tick();
    mst_rsp.r_valid = 1'b0;
    @(negedge clk_i);
    tests_run++;
    if (slv_rsp.ar_ready !== 1'b1 || mst_req.ar_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rl_next_cycle: got ar_ready=%b mst_ar_valid=%b, want 1 1",
               slv_rsp.ar_ready, mst_req.ar_valid);
    end
    tick();
    idx++;
    slv_req.ar.addr = 32'h1000 + 32'(idx) * 32'h40;
    tests_run++;
    if (rd_inflight !== 3'd4) begin
      tests_failed++;
      $display("FAIL rl_refill: got rd=%0d, want 4", rd_inflight);
    end
    for (int c = 0; c < 30 && !(idx == 6 && rd_inflight == 0); c++) begin
      mst_rsp.r_valid = (rd_inflight != 0);
      @(negedge clk_i);
      hs = slv_rsp.ar_ready & slv_req.ar_valid;
      tick();
      if (hs) begin
        idx++;
        if (idx == 6) slv_req.ar_valid = 1'b0;
        else slv_req.ar.addr = 32'h1000 + 32'(idx) * 32'h40;
      end
    end
    mst_rsp.r_valid = 1'b0;
    tests_run++;
    if (idx != 6 || rd_inflight !== 3'd0 || exp_ar_q.size() != 0) begin
      tests_failed++;
      $display("FAIL rl_drain: got fwd=%0d rd=%0d q=%0d, want 6 0 0", idx, rd_inflight, exp_ar_q.size());
    end
  endtask

  task automatic test_w_before_aw();
    for (int b = 0; b < 4; b++) exp_w_q.push_back(64'hA0 + 64'(b));
    slv_req.w.data  = 64'hA0;
    slv_req.w.last  = 1'b0;
    slv_req.w_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      tests_run++;
      if (mst_req.w_valid !== 1'b0 || slv_rsp.w_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL wa_early_w: got w_valid=%b w_ready=%b at cycle %0d, want 0 0",
                 mst_req.w_valid, slv_rsp.w_ready, c);
      end
      tick();
    end
    exp_aw_q.push_back(4'h5);
    slv_req.aw.id    = 4'h5;
    slv_req.aw.len   = 8'd3;
    slv_req.aw.atop  = 6'd0;
    slv_req.aw_valid = 1'b1;
    @(negedge clk_i);
    tests_run++;
    if (mst_req.aw_valid !== 1'b1 || mst_req.w_valid !== 1'b0 || dut.w_pend_reg !== 3'd0) begin
      tests_failed++;
      $display("FAIL wa_aw_cycle: got aw_valid=%b w_valid=%b w_pend=%0d, want 1 0 0",
               mst_req.aw_valid, mst_req.w_valid, dut.w_pend_reg);
    end
    tick();
    slv_req.aw_valid = 1'b0;
    tests_run++;
    if (dut.w_pend_reg !== 3'd1 || wr_inflight !== 3'd1) begin
      tests_failed++;
      $display("FAIL wa_pend_up: got w_pend=%0d wr=%0d, want 1 1", dut.w_pend_reg, wr_inflight);
    end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk_i);
      tests_run++;
      if (mst_req.w_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL wa_beat: got w_valid=%b at beat %0d, want 1", mst_req.w_valid, b);
      end
      tick();
      slv_req.w.data = 64'hA0 + 64'(b + 1);
      slv_req.w.last = (b == 2);
    end
    slv_req.w_valid = 1'b0;
    slv_req.w.last  = 1'b0;
    tests_run++;
    if (dut.w_pend_reg !== 3'd0 || exp_w_q.size() != 0) begin
      tests_failed++;
      $display("FAIL wa_pend_down: got w_pend=%0d q=%0d, want 0 0", dut.w_pend_reg, exp_w_q.size());
    end
    mst_rsp.b.id    = 4'h5;
    mst_rsp.b_valid = 1'b1;
    @(negedge clk_i);
    tests_run++;
    if (slv_rsp.b_valid !== 1'b1 || slv_rsp.b.id !== 4'h5) begin
      tests_failed++;
      $display("FAIL wa_b_pass: got b_valid=%b b.id=%h, want 1 5", slv_rsp.b_valid, slv_rsp.b.id);
    end
    tick();
    mst_rsp.b_valid = 1'b0;
    tests_run++;
    if (wr_inflight !== 3'd0) begin
      tests_failed++;
      $display("FAIL wa_b_done: got wr=%0d, want 0", wr_inflight);
    end
  endtask

  task automatic test_same_cycle();
    for (int i = 0; i < 3; i++) issue_ar(32'h2000 + 32'(i) * 32'h40);
    exp_ar_q.push_back(32'h20C0);
    slv_req.ar.addr  = 32'h20C0;
    slv_req.ar_valid = 1'b1;
    mst_rsp.r_valid  = 1'b1;
    @(negedge clk_i);
    tests_run++;
    if (slv_rsp.ar_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL sc_accept: got ar_ready=%b with rd=3 and R last, want 1", slv_rsp.ar_ready);
    end
    tick();
    slv_req.ar_valid = 1'b0;
    mst_rsp.r_valid  = 1'b0;
    tests_run++;
    if (rd_inflight !== 3'd3) begin
      tests_failed++;
      $display("FAIL sc_hold: got rd=%0d, want 3", rd_inflight);
    end
    issue_ar(32'h2100);
    exp_ar_q.push_back(32'h2140);
    slv_req.ar.addr  = 32'h2140;
    slv_req.ar_valid = 1'b1;
    mst_rsp.r_valid  = 1'b1;
    @(negedge clk_i);
    tests_run++;
    if (slv_rsp.ar_ready !== 1'b0 || rd_inflight !== 3'd4) begin
      tests_failed++;
      $display("FAIL sc_full: got ar_ready=%b rd=%0d, want 0 4", slv_rsp.ar_ready, rd_inflight);
    end
    tick();
    mst_rsp.r_valid = 1'b0;
    @(negedge clk_i);
    tests_run++;
    if (slv_rsp.ar_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL sc_freed: got ar_ready=%b, want 1", slv_rsp.ar_ready);
    end
    tick();
    slv_req.ar_valid = 1'b0;
    tests_run++;
    if (rd_inflight !== 3'd4) begin
      tests_failed++;
      $display("FAIL sc_refill: got rd=%0d, want 4", rd_inflight);
    end
    drain_reads();
  endtask

  task automatic test_atop_full();
    for (int i = 0; i < 4; i++) issue_ar(32'h3000 + 32'(i) * 32'h40);
    exp_aw_q.push_back(4'h9);
    slv_req.aw.id    = 4'h9;
    slv_req.aw.len   = 8'd0;
    slv_req.aw.atop  = 6'b100000;
    slv_req.aw_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      tests_run++;
      if (mst_req.aw_valid !== 1'b0 || slv_rsp.aw_ready !== 1'b0 || wr_inflight !== 3'd0) begin
        tests_failed++;
        $display("FAIL at_stall: got aw_valid=%b aw_ready=%b wr=%0d, want 0 0 0",
                 mst_req.aw_valid, slv_rsp.aw_ready, wr_inflight);
      end
      tick();
    end
    mst_rsp.r_valid = 1'b1;
    tick();
    mst_rsp.r_valid = 1'b0;
    @(negedge clk_i);
    tests_run++;
    if (mst_req.aw_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL at_release: got aw_valid=%b, want 1", mst_req.aw_valid);
    end
    tick();
    slv_req.aw_valid = 1'b0;
    tests_run++;
    if (rd_inflight !== 3'd4 || wr_inflight !== 3'd1) begin
      tests_failed++;
      $display("FAIL at_counts: got rd=%0d wr=%0d, want 4 1", rd_inflight, wr_inflight);
    end
    send_w(1, 64'hB0);
    b_pulse();
    drain_reads();
  endtask

  task automatic test_ar_priority();
    for (int i = 0; i < 3; i++) issue_ar(32'h4000 + 32'(i) * 32'h40);
    exp_ar_q.push_back(32'h40C0);
    exp_aw_q.push_back(4'hC);
    slv_req.ar.addr  = 32'h40C0;
    slv_req.ar_valid = 1'b1;
    slv_req.aw.id    = 4'hC;
    slv_req.aw.len   = 8'd0;
    slv_req.aw.atop  = 6'b100000;
    slv_req.aw_valid = 1'b1;
    @(negedge clk_i);
    tests_run++;
    if (slv_rsp.ar_ready !== 1'b1 || mst_req.aw_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL ap_ar_first: got ar_ready=%b aw_valid=%b, want 1 0",
               slv_rsp.ar_ready, mst_req.aw_valid);
    end
    tick();
    slv_req.ar_valid = 1'b0;
    @(negedge clk_i);
    tests_run++;
    if (mst_req.aw_valid !== 1'b0 || rd_inflight !== 3'd4) begin
      tests_failed++;
      $display("FAIL ap_aw_wait: got aw_valid=%b rd=%0d, want 0 4", mst_req.aw_valid, rd_inflight);
    end
    tick();
    mst_rsp.r_valid = 1'b1;
    tick();
    mst_rsp.r_valid = 1'b0;
    @(negedge clk_i);
    tests_run++;
    if (mst_req.aw_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL ap_aw_go: got aw_valid=%b, want 1", mst_req.aw_valid);
    end
    tick();
    slv_req.aw_valid = 1'b0;
    tests_run++;
    if (rd_inflight !== 3'd4 || wr_inflight !== 3'd1) begin
      tests_failed++;
      $display("FAIL ap_counts: got rd=%0d wr=%0d, want 4 1", rd_inflight, wr_inflight);
    end
    send_w(1, 64'hC0);
    b_pulse();
    drain_reads();
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 3; i++) issue_ar(32'h5000 + 32'(i) * 32'h40);
    issue_aw(4'h1, 6'd0);
    issue_aw(4'h2, 6'd0);
    send_w(1, 64'hD0);
    tests_run++;
    if (rd_inflight !== 3'd3 || wr_inflight !== 3'd2 || dut.w_pend_reg !== 3'd1) begin
      tests_failed++;
      $display("FAIL rm_before: got rd=%0d wr=%0d w_pend=%0d, want 3 2 1",
               rd_inflight, wr_inflight, dut.w_pend_reg);
    end
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    tests_run++;
    if (rd_inflight !== 3'd0 || wr_inflight !== 3'd0 || dut.w_pend_reg !== 3'd0) begin
      tests_failed++;
      $display("FAIL rm_after: got rd=%0d wr=%0d w_pend=%0d, want 0 0 0",
               rd_inflight, wr_inflight, dut.w_pend_reg);
    end
    exp_ar_q.push_back(32'h6000);
    exp_aw_q.push_back(4'h3);
    exp_w_q.push_back(64'hE0);
    slv_req.ar.addr  = 32'h6000;
    slv_req.ar_valid = 1'b1;
    slv_req.aw.id    = 4'h3;
    slv_req.aw.atop  = 6'd0;
    slv_req.aw_valid = 1'b1;
    slv_req.w.data   = 64'hE0;
    slv_req.w.last   = 1'b1;
    slv_req.w_valid  = 1'b1;
    @(negedge clk_i);
    tests_run++;
    if (mst_req.ar_valid !== 1'b1 || mst_req.aw_valid !== 1'b1 || mst_req.w_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rm_first_cycle: got ar=%b aw=%b w=%b, want 1 1 0",
               mst_req.ar_valid, mst_req.aw_valid, mst_req.w_valid);
    end
    tick();
    slv_req.ar_valid = 1'b0;
    slv_req.aw_valid = 1'b0;
    @(negedge clk_i);
    tests_run++;
    if (mst_req.w_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rm_w_open: got w_valid=%b, want 1", mst_req.w_valid);
    end
    tick();
    slv_req.w_valid = 1'b0;
    slv_req.w.last  = 1'b0;
    b_pulse();
    drain_reads();
    tests_run++;
    if (wr_inflight !== 3'd0) begin
      tests_failed++;
      $display("FAIL rm_end: got wr=%0d, want 0", wr_inflight);
    end
  endtask

  initial begin
    slv_req = '0;
    mst_rsp = '0;
    slv_req.r_ready = 1'b1;
    slv_req.b_ready = 1'b1;
    mst_rsp.r.last  = 1'b1;

    test_reset();
    test_read_limit();
    test_w_before_aw();
    test_same_cycle();
    test_atop_full();
    test_ar_priority();
    test_reset_midop();

    tests_run++;
    if (exp_ar_q.size() != 0 || exp_aw_q.size() != 0 || exp_w_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_leftover: got ar=%0d aw=%0d w=%0d pending, want 0 0 0",
               exp_ar_q.size(), exp_aw_q.size(), exp_w_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
